// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the multi-channel LED pulse stretcher.
// Latency/backpressure: none here; package only.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Never let the counter collapse to zero width when both durations are 1.
    function automatic int cnt_width(input int on_cycles, input int gap_cycles);
        int w;
        w = $clog2(max(on_cycles, gap_cycles));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stretch_channel.sv
// One LED channel: stretches strobes into ON_CYCLES blinks separated by GAP_CYCLES dark gaps.
// Latency 1 cycle strobe-to-LED; no backpressure, strobes beyond the pending limit are dropped and flagged.
module stretch_channel
    import pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = 5_000_000,
    parameter int GAP_CYCLES = 2_500_000,
    parameter int PEND_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clr_overflow,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int                 CNT_W    = cnt_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0]   ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PEND_W-1:0]   r_pend;
    logic                r_ovf;
    logic                r_led;

    logic w_cnt_zero;
    logic w_gap_end;
    logic w_launch;
    logic w_inc;
    logic w_sat;

    always_comb begin
        w_cnt_zero = (r_cnt == '0);
        w_gap_end  = (r_state == GAP) && w_cnt_zero;
        w_launch   = w_gap_end && (r_pend != '0);
        // A strobe is queued unless it directly starts a blink (from IDLE or an empty-queue gap end).
        w_inc      = pulse_in && ((r_state == ON) ||
                                  ((r_state == GAP) && !(w_gap_end && (r_pend == '0))));
        w_sat      = w_inc && !w_launch && (r_pend == PEND_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pulse_in) begin
                        r_state <= ON;
                        r_cnt   <= ON_LOAD;
                        r_led   <= 1'b1;
                    end
                end
                ON: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= GAP;
                        r_cnt   <= GAP_LOAD;
                        r_led   <= 1'b0;
                    end
                end
                GAP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if ((r_pend != '0) || pulse_in) begin
                        r_state <= ON;
                        r_cnt   <= ON_LOAD;
                        r_led   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_led   <= 1'b0;
                end
            endcase

            case ({w_inc, w_launch})
                2'b10:   if (!w_sat) r_pend <= r_pend + PEND_W'(1);
                2'b01:   r_pend <= r_pend - PEND_W'(1);
                default: r_pend <= r_pend;
            endcase

            // A lost event in the same cycle as a clear keeps the flag set.
            if (w_sat) begin
                r_ovf <= 1'b1;
            end else if (clr_overflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign led_out  = r_led;
    assign pending  = r_pend;
    assign overflow = r_ovf;
    assign busy     = (r_state != IDLE) || (r_pend != '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel activity indicator: independent stretch_channel per strobe input, pending counts packed.
// Latency 1 cycle strobe-to-LED; no backpressure, overflowing strobes are dropped and flagged per channel.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int ON_CYCLES  = 5_000_000,
    parameter int GAP_CYCLES = 2_500_000,
    parameter int PEND_W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        pulse_in,
    input  logic [CHANNELS-1:0]        clr_overflow,
    output logic [CHANNELS-1:0]        led_out,
    output logic [CHANNELS-1:0]        busy,
    output logic [CHANNELS*PEND_W-1:0] pending,
    output logic [CHANNELS-1:0]        overflow
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [PEND_W-1:0] w_pend;

        stretch_channel #(
            .ON_CYCLES  (ON_CYCLES),
            .GAP_CYCLES (GAP_CYCLES),
            .PEND_W     (PEND_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .pulse_in     (pulse_in[g]),
            .clr_overflow (clr_overflow[g]),
            .led_out      (led_out[g]),
            .busy         (busy[g]),
            .pending      (w_pend),
            .overflow     (overflow[g])
        );

        assign pending[g*PEND_W +: PEND_W] = w_pend;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed vector table, hand-written corner sequences and a random run
// checked every cycle against a timeline-based reference model.
module tb_pulse_stretcher;

    localparam int CH   = 2;
    localparam int ONC  = 4;
    localparam int GAPC = 2;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;
    localparam int PER  = ONC + GAPC;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [CH-1:0]   pulse_in = '0;
    logic [CH-1:0]   clr_overflow = '0;
    logic [CH-1:0]   led_out;
    logic [CH-1:0]   busy;
    logic [CH*PW-1:0] pending;
    logic [CH-1:0]   overflow;

    int n_vec = 0;
    int n_bad = 0;

    // Model: edges elapsed since the current blink started (-1 when idle), plus queue depth.
    int m_age [CH];
    int m_pend[CH];
    bit m_ovf [CH];

    typedef struct {
        logic          rst;
        logic [CH-1:0] pulse;
        logic [CH-1:0] clr;
        logic [CH-1:0] led;
        logic [CH*PW-1:0] pend;
        logic [CH-1:0] busy;
        logic [CH-1:0] ovf;
    } vec_t;

    vec_t tbl[$];

    pulse_stretcher #(
        .CHANNELS   (CH),
        .ON_CYCLES  (ONC),
        .GAP_CYCLES (GAPC),
        .PEND_W     (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .clr_overflow (clr_overflow),
        .led_out      (led_out),
        .busy         (busy),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [CH-1:0] p, input logic [CH-1:0] c);
        for (int i = 0; i < CH; i++) begin
            bit inc;
            inc = 1'b0;
            if (r) begin
                m_age[i]  = -1;
                m_pend[i] = 0;
                m_ovf[i]  = 1'b0;
            end else begin
                if (m_age[i] < 0) begin
                    if (p[i]) m_age[i] = 0;
                end else if (m_age[i] == PER - 1) begin
                    if (m_pend[i] > 0) begin
                        m_age[i] = 0;
                        m_pend[i]--;
                        inc = p[i];
                    end else if (p[i]) begin
                        m_age[i] = 0;
                    end else begin
                        m_age[i] = -1;
                    end
                end else begin
                    m_age[i]++;
                    inc = p[i];
                end
                if (inc && m_pend[i] == PMAX) m_ovf[i] = 1'b1;
                else begin
                    if (inc) m_pend[i]++;
                    if (c[i]) m_ovf[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [CH-1:0] p, input logic [CH-1:0] c);
        logic [CH-1:0]    e_led, e_busy, e_ovf;
        logic [CH*PW-1:0] e_pend;
        reset        = r;
        pulse_in     = p;
        clr_overflow = c;
        @(posedge clk);
        model_edge(r, p, c);
        #1;
        for (int i = 0; i < CH; i++) begin
            e_led[i]  = (m_age[i] >= 0) && (m_age[i] < ONC);
            e_busy[i] = (m_age[i] >= 0) || (m_pend[i] != 0);
            e_ovf[i]  = m_ovf[i];
            e_pend[i*PW +: PW] = PW'(m_pend[i]);
        end
        check("model", 16'({led_out, busy, pending, overflow}), 16'({e_led, e_busy, e_pend, e_ovf}));
    endtask

    function automatic vec_t mk(input logic r, input logic p0, input logic led0,
                                input logic [PW-1:0] pend0, input logic busy0);
        vec_t v;
        v.rst   = r;
        v.pulse = {1'b0, p0};
        v.clr   = '0;
        v.led   = {1'b0, led0};
        v.pend  = {{PW{1'b0}}, pend0};
        v.busy  = {1'b0, busy0};
        v.ovf   = '0;
        return v;
    endfunction

    task automatic add(input int n, input logic r, input logic p0, input logic led0,
                       input logic [PW-1:0] pend0, input logic busy0);
        for (int k = 0; k < n; k++) tbl.push_back(mk(r, p0, led0, pend0, busy0));
    endtask

    initial begin
        int blinks;
        logic prev_led;
        int dens;
        logic r;
        logic [CH-1:0] p, c;

        for (int i = 0; i < CH; i++) begin
            m_age[i] = -1; m_pend[i] = 0; m_ovf[i] = 1'b0;
        end

        // Single strobe
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1);
        add(3, 0, 0, 1, 0, 1);
        add(2, 0, 0, 0, 0, 1);
        add(2, 0, 0, 0, 0, 0);
        // Three strobes queued and replayed
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1);
        add(1, 0, 1, 1, 1, 1);
        add(1, 0, 1, 1, 2, 1);
        add(1, 0, 0, 1, 2, 1);
        add(2, 0, 0, 0, 2, 1);
        add(4, 0, 0, 1, 1, 1);
        add(2, 0, 0, 0, 1, 1);
        add(4, 0, 0, 1, 0, 1);
        add(2, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0);
        // Strobe on the last gap cycle restarts with no extra gap
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1);
        add(3, 0, 0, 1, 0, 1);
        add(2, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 1);
        add(3, 0, 0, 1, 0, 1);
        add(2, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0);

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].pulse, tbl[k].clr);
            check($sformatf("table[%0d]", k), 16'({led_out, busy, pending, overflow}),
                  16'({tbl[k].led, tbl[k].busy, tbl[k].pend, tbl[k].ovf}));
        end

        // Six consecutive strobes: saturation, overflow, clear, four blinks
        step(1, 2'b00, 2'b00);
        blinks = 0; prev_led = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(0, (k < 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00);
            if (led_out[0] && !prev_led) blinks++;
            prev_led = led_out[0];
            if (k == 3) check("sat_pre", 16'({pending[1:0], overflow[0]}), 16'({2'd3, 1'b0}));
            if (k == 5) check("sat_ovf", 16'({pending[1:0], overflow[0]}), 16'({2'd3, 1'b1}));
            if (k == 6) check("ovf_clr", 16'({pending[1:0], overflow[0]}), 16'({2'd2, 1'b0}));
        end
        check("sat_blinks", 16'(blinks), 16'd4);
        check("sat_idle", 16'(busy[0]), 16'd0);

        // Clear and saturating strobe together: set wins
        step(1, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++) step(0, 2'b01, 2'b00);
        step(0, 2'b01, 2'b01);
        check("set_wins", 16'({pending[1:0], overflow[0]}), 16'({2'd3, 1'b1}));
        step(0, 2'b00, 2'b01);
        check("clr_after", 16'({pending[1:0], overflow[0]}), 16'({2'd2, 1'b0}));

        // Reset mid-blink with queued event and simultaneous strobe
        step(1, 2'b00, 2'b00);
        step(0, 2'b01, 2'b00);
        step(0, 2'b01, 2'b00);
        check("pre_rst_pend", 16'(pending), 16'd1);
        step(1, 2'b01, 2'b00);
        check("mid_rst", 16'({led_out, busy, pending, overflow}), 16'd0);
        step(0, 2'b00, 2'b00);
        check("rst_ignored", 16'({led_out, busy, pending, overflow}), 16'd0);

        // Independent channels
        step(0, 2'b11, 2'b00);
        check("two_ch_a", 16'({led_out, pending}), 16'({2'b11, 4'b0000}));
        step(0, 2'b10, 2'b00);
        check("two_ch_b", 16'({led_out, pending}), 16'({2'b11, 4'b0100}));

        // Random traffic on both channels against the model
        dens = 4;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) dens = int'($urandom_range(1, 10));
            r = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < CH; i++) begin
                p[i] = ($urandom_range(0, 15) < dens);
                c[i] = ($urandom_range(0, 15) == 0);
            end
            step(r, p, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
